// File: rtl/div_share_arb.sv
// rtl/div_share_arb.sv - round-robin arbiter sharing one iterative divider among requesters
module div_share_arb #(
  parameter int WIDTH   = 5,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_q,
  output logic [WIDTH-1:0]        rsp_r,
  output logic                    rsp_dbz,
  output logic                    rsp_err,
  output logic                    div_start,
  output logic [WIDTH-1:0]        div_a,
  output logic [WIDTH-1:0]        div_b,
  input  logic                    div_busy,
  input  logic                    div_done,
  input  logic                    div_valid,
  input  logic                    div_dbz,
  input  logic [WIDTH-1:0]        div_val,
  input  logic [WIDTH-1:0]        div_rem
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] sel_id;
  logic           sel_found;
  logic [IDW:0]   cand;
  logic [CW-1:0]  wait_cnt;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // Round-robin pick: first active request at or after ptr, wrapping at NREQ
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!sel_found && req[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  // Next-state and divider start; start is held off while a stale op is still running
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      IDLE:  if (sel_found) state_nx = ISSUE;
      ISSUE: begin
        div_start = !div_busy;
        if (!div_busy) state_nx = WAIT;
      end
      WAIT:  if (div_done || wait_cnt == CNT_MAX) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand latch, grant pulse, wait counter, response capture and pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      wait_cnt <= '0;
      gnt      <= '0;
      rsp_id   <= '0;
      rsp_q    <= '0;
      rsp_r    <= '0;
      rsp_dbz  <= 1'b0;
      rsp_err  <= 1'b0;
      div_a    <= '0;
      div_b    <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            div_a  <= a_arr[sel_id];
            div_b  <= b_arr[sel_id];
            rsp_id <= sel_id;
            gnt    <= NREQ'(1) << sel_id;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (div_done) begin
            rsp_dbz <= div_dbz;
            rsp_err <= !div_dbz && !div_valid;
            rsp_q   <= (!div_dbz && div_valid) ? div_val : '0;
            rsp_r   <= (!div_dbz && div_valid) ? div_rem : '0;
          end else if (wait_cnt == CNT_MAX) begin
            rsp_dbz <= 1'b0;
            rsp_err <= 1'b1;
            rsp_q   <= '0;
            rsp_r   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) ptr <= (rsp_id == LAST_ID) ? '0 : rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arb.sv
// tb/tb_div_share_arb.sv - scoreboard bench for div_share_arb with a behavioural divider
module tb_div_share_arb;

  localparam int W  = 5;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   gnt;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_q, rsp_r;
  logic           rsp_dbz, rsp_err;
  logic           div_start;
  logic [W-1:0]   div_a, div_b;
  logic           div_busy, div_done, div_valid, div_dbz;
  logic [W-1:0]   div_val, div_rem;

  div_share_arb #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .rsp_err(rsp_err), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_busy(div_busy), .div_done(div_done),
    .div_valid(div_valid), .div_dbz(div_dbz), .div_val(div_val), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int q; int r; int dbz; int err;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0 normal divider, 1 never signals done, 2 done without valid/dbz

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int id, input int a, input int b);
    exp_t e;
    e.id = id; e.q = 0; e.r = 0; e.dbz = 0; e.err = 0;
    if (mode != 0) e.err = 1;
    else if (b == 0) e.dbz = 1;
    else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic issue(input int idx, input int a, input int b);
    req_a[idx*W +: W] = W'(a);
    req_b[idx*W +: W] = W'(b);
    req[idx] = 1'b1;
    sb.push_back(model(idx, a, b));
  endtask

  // Divider stand-in: done WIDTH+1 cycles after start, or 2 cycles for a zero divisor
  int dm_rem, dm_a, dm_b;
  bit dm_st, dm_z, dm_fin;
  initial begin
    div_busy = 0; div_done = 0; div_valid = 0; div_dbz = 0; div_val = 0; div_rem = 0;
    dm_fin = 0; dm_rem = 0; dm_z = 0;
    forever begin
      @(negedge clk);
      dm_st = div_start; dm_a = int'(div_a); dm_b = int'(div_b);
      @(posedge clk); #1;
      if (dm_st) begin
        div_busy = 1; dm_fin = 0;
        dm_z = (dm_b == 0);
        dm_rem = dm_z ? 1 : W;
        if (dm_z) begin
          div_val = '0; div_rem = '0;
        end else begin
          div_val = W'(dm_a / dm_b); div_rem = W'(dm_a % dm_b);
        end
      end else if (div_busy) begin
        if (dm_fin) begin
          div_busy = 0; div_done = 0; div_valid = 0; div_dbz = 0; dm_fin = 0;
        end else begin
          dm_rem--;
          if (dm_rem == 0) begin
            dm_fin = 1;
            if (mode != 1) begin
              div_done  = 1;
              div_valid = (mode == 0) && !dm_z;
              div_dbz   = (mode == 0) && dm_z;
            end
          end
        end
      end
    end
  end

  // Response monitor: pops the oldest outstanding expectation for the responding requester
  int mon_k;
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      mon_k = -1;
      foreach (sb[j]) if (mon_k < 0 && sb[j].id == int'(rsp_id)) mon_k = j;
      if (mon_k < 0) chk("rsp_expected", 0, 1);
      else begin
        chk("rsp_q", int'(rsp_q), sb[mon_k].q);
        chk("rsp_r", int'(rsp_r), sb[mon_k].r);
        chk("rsp_dbz", int'(rsp_dbz), sb[mon_k].dbz);
        chk("rsp_err", int'(rsp_err), sb[mon_k].err);
        sb.delete(mon_k);
      end
    end
  end

  int cyc, first_gnt, first_start, start_cnt, valid_cyc;
  logic [N-1:0] first_gnt_val;
  logic [N-1:0] gnt_log[$];
  bit drop_on_gnt;
  logic [N-1:0] s_gnt;
  logic s_valid, s_dbz, s_err, s_start;
  int s_id, s_q, s_r, s_a, s_b;

  task automatic step();
    @(negedge clk);
    s_gnt = gnt; s_valid = rsp_valid; s_id = int'(rsp_id); s_q = int'(rsp_q); s_r = int'(rsp_r);
    s_dbz = rsp_dbz; s_err = rsp_err; s_start = div_start; s_a = int'(div_a); s_b = int'(div_b);
    if (s_gnt != 0) begin
      gnt_log.push_back(s_gnt);
      if (first_gnt < 0) begin first_gnt = cyc; first_gnt_val = s_gnt; end
    end
    if (s_start) begin
      start_cnt++;
      if (first_start < 0) first_start = cyc;
    end
    if (s_valid && valid_cyc < 0) valid_cyc = cyc;
    @(posedge clk); #1;
    cyc++;
    if (drop_on_gnt) req = req & ~s_gnt;
  endtask

  task automatic clear_trace();
    cyc = 0; first_gnt = -1; first_start = -1; start_cnt = 0; valid_cyc = -1;
    first_gnt_val = '0; gnt_log.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, int'(s_gnt), 0);
    chk({tag, "_valid"}, int'(s_valid), 0);
    chk({tag, "_id"}, s_id, 0);
    chk({tag, "_q"}, s_q, 0);
    chk({tag, "_r"}, s_r, 0);
    chk({tag, "_dbz"}, int'(s_dbz), 0);
    chk({tag, "_err"}, int'(s_err), 0);
    chk({tag, "_div_a"}, s_a, 0);
    chk({tag, "_div_b"}, s_b, 0);
    chk({tag, "_start"}, int'(s_start), 0);
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1;
    for (int n = 0; n < 400 && (sb.size() != 0 || req != 0); n++) step();
    chk({tag, "_drained"}, sb.size(), 0);
    step();
  endtask

  task automatic run_single(input int idx, input int a, input int b,
                            input int exp_valid, input string tag);
    clear_trace();
    issue(idx, a, b);
    for (int n = 0; n < 60 && valid_cyc < 0; n++) step();
    chk({tag, "_gnt_cycle"}, first_gnt, 1);
    chk({tag, "_gnt_onehot"}, int'(first_gnt_val), 1 << idx);
    chk({tag, "_start_count"}, start_cnt, 1);
    chk({tag, "_valid_cycle"}, valid_cyc, exp_valid);
    drain(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int bad;
  int ra, rb;
  initial begin
    req = '0; req_a = '0; req_b = '0; rsp_ready = 1; drop_on_gnt = 1;
    clear_trace();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // reset state
    step();
    check_idle_outputs("reset");

    // single requests with exact latency
    run_single(1, 23, 4, W + 3, "single");
    run_single(0, 9, 0, 4, "dbz");

    // all requesters held: strict rotation from index 0
    rst = 1; step(); rst = 0;
    clear_trace();
    drop_on_gnt = 0;
    issue(0, 31, 3); issue(1, 17, 5); issue(2, 26, 7); issue(3, 12, 0);
    sb.push_back(model(0, 31, 3));
    for (int n = 0; n < 300 && gnt_log.size() < 5; n++) step();
    req = '0;
    drop_on_gnt = 1;
    chk("rr_grant_count", gnt_log.size(), 5);
    for (int k = 0; k < gnt_log.size() && k < 5; k++)
      chk("rr_order", int'(gnt_log[k]), 1 << (k % N));
    drain("rr");

    // backpressure: response held, nothing issued, then rotation continues
    clear_trace();
    rsp_ready = 0;
    issue(2, 29, 6);
    for (int n = 0; n < 40 && valid_cyc < 0; n++) step();
    chk("stall_valid_seen", int'(valid_cyc >= 0), 1);
    issue(0, 11, 2);
    issue(3, 25, 4);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (s_gnt != 0 || s_start || !s_valid || s_id != 2 || s_q != 4 || s_r != 5) bad++;
    end
    chk("stall_hold_bad_cycles", bad, 0);
    gnt_log.delete();
    rsp_ready = 1;
    for (int n = 0; n < 40 && gnt_log.size() == 0; n++) step();
    chk("stall_next_grant", (gnt_log.size() > 0) ? int'(gnt_log[0]) : 0, 4'b1000);
    drain("stall");

    // divider never completes: error after TIMEOUT cycles in WAIT
    mode = 1;
    run_single(1, 10, 2, 2 + TO, "timeout");
    // divider done without valid or dbz
    mode = 2;
    run_single(3, 22, 3, W + 3, "nodone");
    mode = 0;

    // reset while divider is busy; new op must wait for the stale one to drain
    clear_trace();
    issue(0, 30, 7);
    step(); step(); step();
    rst = 1;
    sb.delete();
    step();
    rst = 0;
    issue(2, 19, 4);
    first_start = -1; start_cnt = 0; valid_cyc = -1;
    step();
    check_idle_outputs("midreset");
    for (int n = 0; n < 60 && valid_cyc < 0; n++) step();
    chk("midreset_start_cycle", first_start, 8);
    chk("midreset_valid_cycle", valid_cyc, 15);
    drain("midreset");

    // randomized traffic with random backpressure
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(3) == 0) begin
          ra = int'($urandom_range(31));
          rb = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(31));
          issue(i, ra, rb);
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one iterative unsigned divider (start/busy/done/valid/dbz handshake) among NREQ requesters.
- Selects a requester, latches its operands and pulses the divider start.
- Waits for completion and returns quotient/remainder/status on a single valid/ready response channel tagged with the requester index.
- Sits between client blocks and the single divider instance; the divider is instantiated outside this block.

Parameters:
WIDTH, 5, operand/result width in bits (matches divider WIDTH)
NREQ, 4, number of requesters (2..8)
TIMEOUT, 16, max cycles in WAIT before forcing an error response

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req  in  NREQ  per-requester request; held high with operands until gnt
req_a  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  divisors, same packing
gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester accepted
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  $clog2(NREQ)  index of requester the response belongs to
rsp_q  out  WIDTH  quotient
rsp_r  out  WIDTH  remainder
rsp_dbz  out  1  divide by zero
rsp_err  out  1  timeout or divider done without valid/dbz
div_start  out  1  start pulse to divider
div_a  out  WIDTH  dividend to divider
div_b  out  WIDTH  divisor to divider
div_busy  in  1  divider busy
div_done  in  1  divider done pulse
div_valid  in  1  divider result valid
div_dbz  in  1  divider divide-by-zero flag
div_val  in  WIDTH  divider quotient
div_rem  in  WIDTH  divider remainder

Behaviour:
- Reset (rst high at a clk edge): state IDLE, ptr=0, wait counter 0. gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err, div_a, div_b all 0. div_start is 0 because the state is IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP. Only one operation is in flight at a time.
- IDLE: if req != 0, select the first set bit searching ptr, ptr+1, ... mod NREQ.
  - Latch req_a/req_b slice into div_a/div_b and index into rsp_id.
  - Next cycle: gnt[id]=1 for exactly one cycle; state ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE: div_start = (state==ISSUE) && !div_busy (combinational). When asserted, go to WAIT next cycle with wait counter cleared. While div_busy=1, hold in ISSUE with div_start=0.
- WAIT: div_done=1 captures the result and moves to RESP:
  - div_dbz=1: rsp_dbz=1, rsp_q=0, rsp_r=0, rsp_err=0.
  - else div_valid=1: rsp_q=div_val, rsp_r=div_rem, rsp_dbz=0, rsp_err=0.
  - else: rsp_err=1, rsp_q/rsp_r/rsp_dbz=0.
  - Counter increments each WAIT cycle without done. When it reaches TIMEOUT-1 with no done, go to RESP with rsp_err=1 and q/r/dbz=0.
- RESP: rsp_valid=1, and all rsp_* stay stable until rsp_valid && rsp_ready. On that handshake: ptr=(rsp_id+1) mod NREQ, state IDLE, rsp_valid=0. Arbitration therefore restarts the cycle after the handshake.
- div_done, div_valid and div_dbz are ignored in every state except WAIT.
- Latency (cycle 0 = IDLE cycle with req seen, divider idle, rsp_ready=1):
  - gnt and div_start in cycle 1.
  - Nonzero divisor: div_done in cycle WIDTH+2; rsp_valid in cycle WIDTH+3 (cycle 8 for WIDTH=5).
  - Divisor 0: div_done in cycle 3; rsp_valid in cycle 4.
- Reset mid-operation: the block returns to IDLE immediately. A divider op still running is not aborted. The next ISSUE waits for div_busy=0, so a stale done is never attributed to a new request.
- Simultaneous req from all requesters: each is served exactly once per NREQ grants (strict rotation from ptr).
- A requester deasserting req before gnt is never granted. If it deasserts after it was selected in IDLE, it is still granted and served, since its operands are already latched.

Test Plan:
- Single requester, rst released, req[1]=1 with a=23, b=4 (WIDTH=5): gnt=0010 in cycle 1, single div_start; rsp_valid in cycle 8 with rsp_id=1, rsp_q=5, rsp_r=3, dbz=0, err=0.
- req[0] with a=9, b=0: rsp_valid in cycle 4 with rsp_dbz=1, rsp_q=0, rsp_r=0, err=0.
- All four req held continuously, rsp_ready=1: grant order 0,1,2,3,0; each response rsp_id matches the grant and has correct q/r for distinct operands (e.g. 31/3 -> 10 rem 1, 17/5 -> 3 rem 2).
- rsp_ready held 0 for 10 cycles during RESP: rsp_* stable, no gnt and no div_start issued; after ready=1, next grant goes to the next index.
- Divider model never asserts done: rsp_err=1 arrives TIMEOUT cycles after WAIT entry, with q=r=0. Divider model asserting done with valid=0 and dbz=0: rsp_err=1.
- rst pulsed while in WAIT with divider busy: all outputs return to 0. A new req then issues div_start only after div_busy drops, and the response carries the new operands' result.
